score_display: RTL and testbench

//  Multi-digit seven-column-free bitmap score renderer for the pong VGA path. Accepts a binary

---
 rtl/score_display_pkg.sv | 59 +++++
 rtl/score_display_bin2bcd_seq.sv | 105 ++++++++++
 rtl/score_display.sv | 168 ++++++++++++++++
 tb/tb_score_display.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// ============================================================================
// score_display_pkg : glyph constants, 4x9 digit font ROM, converter states
// Revision 1.0
// ============================================================================
`default_nettype none

package score_display_pkg;

    localparam int GLYPH_W = 4;
    localparam int GLYPH_H = 9;
    localparam int PITCH   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Column mask, bit 0 = top row. Inner columns 1 and 2 are always identical.
    function automatic logic [GLYPH_H-1:0] glyph_col(input logic [3:0] digit,
                                                     input logic [1:0] col);
        logic [GLYPH_H-1:0] left;
        logic [GLYPH_H-1:0] inner;
        logic [GLYPH_H-1:0] right;
        left  = '0;
        inner = '0;
        right = '0;
        case (digit)
            4'd0: begin left = 9'h1FF; inner = 9'h101; right = 9'h1FF; end
            4'd1: begin left = 9'h000; inner = 9'h000; right = 9'h1FF; end
            4'd2: begin left = 9'h1F1; inner = 9'h111; right = 9'h11F; end
            4'd3: begin left = 9'h111; inner = 9'h111; right = 9'h1FF; end
            4'd4: begin left = 9'h01F; inner = 9'h010; right = 9'h1FF; end
            4'd5: begin left = 9'h11F; inner = 9'h111; right = 9'h1F1; end
            4'd6: begin left = 9'h1FF; inner = 9'h111; right = 9'h1F1; end
            4'd7: begin left = 9'h001; inner = 9'h001; right = 9'h1FF; end
            4'd8: begin left = 9'h1FF; inner = 9'h111; right = 9'h1FF; end
            4'd9: begin left = 9'h11F; inner = 9'h111; right = 9'h1FF; end
            default: begin left = '0; inner = '0; right = '0; end
        endcase
        case (col)
            2'd0:    return left;
            2'd3:    return right;
            default: return inner;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_display_bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble binary to BCD with saturation
// Revision 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int VALUE_W = 7,
    parameter int DIGITS  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [VALUE_W-1:0]  value_i,
    output logic                busy_o,
    output logic                commit_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                overflow_o
);

    // Working register wide enough for the full input range, so the shift
    // never loses carries even when the result saturates.
    localparam int          CONV_N  = ((VALUE_W + 2) / 3 > DIGITS) ? (VALUE_W + 2) / 3 : DIGITS;
    localparam int          CONV_W  = 4 * CONV_N;
    localparam int          CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    conv_state_e        state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [CONV_W-1:0]  bcd_q, bcd_d;
    logic [CONV_W-1:0]  bcd_adj;
    logic [CONV_W-1:0]  bcd_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               last_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < CONV_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[CONV_W-2:0], bin_q[VALUE_W-1]};
    end

    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(VALUE_W - 1));

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    bin_d   = value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 32'(value_i) > MAX_VAL;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = {bin_q[VALUE_W-2:0], 1'b0};
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 1'b1;
                if (last_shift) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The result is presented on the final shift so the owner can latch it on
    // the same edge that drops busy; DONE is the one-cycle dead time after.
    assign busy_o     = (state_q == ST_SHIFT);
    assign commit_o   = last_shift;
    assign bcd_o      = ovf_q ? {DIGITS{4'h9}} : bcd_shift[4*DIGITS-1:0];
    assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/score_display.sv
// ============================================================================
// score_display : N-digit scaled bitmap score renderer with 2-cycle pixel poll
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros. Revision 1.0
// ============================================================================
`default_nettype none

module score_display
    import score_display_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int VALUE_W = 7,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int GLYPH_W = score_display_pkg::GLYPH_W,
    parameter int GLYPH_H = score_display_pkg::GLYPH_H,
    parameter int PITCH   = score_display_pkg::PITCH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Load,
    input  logic [VALUE_W-1:0] Value,
    output logic               Busy,
    output logic               Overflow,
    input  logic [X_W-1:0]     ObjectX,
    input  logic [Y_W-1:0]     ObjectY,
    input  logic [1:0]         ObjectScale,
    input  logic [X_W-1:0]     PollX,
    input  logic [Y_W-1:0]     PollY,
    output logic               Hit
);

    localparam int DSEL_W = $clog2(DIGITS + 1);
    localparam int COL_W  = $clog2(GLYPH_W);
    localparam int ROW_W  = $clog2(GLYPH_H);

    logic                  conv_commit;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic                  conv_ovf;

    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic                   ovf_q, ovf_d;
    logic [DIGITS-1:0]      blank;

    logic [X_W:0]           dx_full;
    logic [Y_W:0]           dy_full;
    logic [X_W-1:0]         dx;
    logic [Y_W-1:0]         dy;
    logic [DSEL_W-1:0]      dsel;
    logic [X_W-1:0]         dsel_off;
    logic [X_W-1:0]         col_full;

    logic                   s1_ok_q, s1_ok_d;
    logic [DSEL_W-1:0]      s1_dig_q, s1_dig_d;
    logic [COL_W-1:0]       s1_col_q, s1_col_d;
    logic [ROW_W-1:0]       s1_row_q, s1_row_d;

    logic [3:0]             sel_digit;
    logic                   sel_blank;
    logic [score_display_pkg::GLYPH_H-1:0] glyph_bits;
    logic                   hit_q, hit_d;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk        (clk),
        .reset      (reset),
        .load_i     (Load),
        .value_i    (Value),
        .busy_o     (Busy),
        .commit_o   (conv_commit),
        .bcd_o      (conv_bcd),
        .overflow_o (conv_ovf)
    );

    // Display position 0 is the leftmost (most significant) digit.
    always_comb begin
        digits_d = digits_q;
        ovf_d    = ovf_q;
        if (conv_commit) begin
            for (int p = 0; p < DIGITS; p++) begin
                digits_d[p] = conv_bcd[4*(DIGITS-1-p) +: 4];
            end
            ovf_d = conv_ovf;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int p = 0; p < DIGITS - 1; p++) begin
            lead     = lead && (digits_q[p] == 4'd0);
            blank[p] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    assign dx_full = {1'b0, PollX} - {1'b0, ObjectX};
    assign dy_full = {1'b0, PollY} - {1'b0, ObjectY};
    assign dx      = dx_full[X_W-1:0] >> ObjectScale;
    assign dy      = dy_full[Y_W-1:0] >> ObjectScale;

    // Highest digit whose origin lies at or left of dx; one comparator per digit.
    always_comb begin
        dsel     = '0;
        dsel_off = '0;
        for (int d = 1; d <= DIGITS; d++) begin
            if (dx >= X_W'(d * PITCH)) begin
                dsel     = DSEL_W'(d);
                dsel_off = X_W'(d * PITCH);
            end
        end
        col_full = dx - dsel_off;
    end

    always_comb begin
        s1_ok_d  = !dx_full[X_W] && !dy_full[Y_W]
                   && (dy < Y_W'(GLYPH_H))
                   && (dsel < DSEL_W'(DIGITS))
                   && (col_full < X_W'(GLYPH_W));
        s1_dig_d = dsel;
        s1_col_d = col_full[COL_W-1:0];
        s1_row_d = dy[ROW_W-1:0];
    end

    always_comb begin
        sel_digit = '0;
        sel_blank = 1'b0;
        for (int p = 0; p < DIGITS; p++) begin
            if (s1_dig_q == DSEL_W'(p)) begin
                sel_digit = digits_q[p];
                sel_blank = blank[p];
            end
        end
        glyph_bits = glyph_col(sel_digit, s1_col_q);
        hit_d      = s1_ok_q && !sel_blank && glyph_bits[s1_row_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            s1_ok_q  <= 1'b0;
            s1_dig_q <= '0;
            s1_col_q <= '0;
            s1_row_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            s1_ok_q  <= s1_ok_d;
            s1_dig_q <= s1_dig_d;
            s1_col_q <= s1_col_d;
            s1_row_q <= s1_row_d;
            hit_q    <= hit_d;
        end
    end

    assign Overflow = ovf_q;
    assign Hit      = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
// ============================================================================
// tb_score_display : table vectors plus scoreboarded polls for score_display
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_score_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Load;
    logic [6:0] Value;
    logic       Busy;
    logic       Overflow;
    logic [9:0] ObjectX;
    logic [8:0] ObjectY;
    logic [1:0] ObjectScale;
    logic [9:0] PollX;
    logic [8:0] PollY;
    logic       Hit;

    always #5 clk = ~clk;

    score_display dut (
        .clk         (clk),
        .reset       (rst_n),
        .Load        (Load),
        .Value       (Value),
        .Busy        (Busy),
        .Overflow    (Overflow),
        .ObjectX     (ObjectX),
        .ObjectY     (ObjectY),
        .ObjectScale (ObjectScale),
        .PollX       (PollX),
        .PollY       (PollY),
        .Hit         (Hit)
    );

    int checks = 0;
    int errors = 0;
    int md[2];
    bit m_ov;

    typedef struct { bit chk; bit exp; int tag; } sb_t;
    sb_t sbq[$];

    typedef struct { int px; int py; int ox; int oy; int sc; bit exp; } vec_t;
    vec_t tbl[21];

    function automatic string rep(string s, int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    // Font as 9 rows of 4 characters, top row first.
    function automatic string font(int d);
        case (d)
            0: return {"####", rep("#..#", 7), "####"};
            1: return rep("...#", 9);
            2: return {"####", rep("...#", 3), "####", rep("#...", 3), "####"};
            3: return {"####", rep("...#", 3), "####", rep("...#", 3), "####"};
            4: return {rep("#..#", 4), "####", rep("...#", 4)};
            5: return {"####", rep("#...", 3), "####", rep("...#", 3), "####"};
            6: return {"####", rep("#...", 3), "####", rep("#..#", 3), "####"};
            7: return {"####", rep("...#", 8)};
            8: return {"####", rep("#..#", 3), "####", rep("#..#", 3), "####"};
            default: return {"####", rep("#..#", 3), "####", rep("...#", 3), "####"};
        endcase
    endfunction

    function automatic bit model_hit(int px, int py, int ox, int oy, int sc);
        int dx, dy, d, c;
        string s;
        if (px < ox || py < oy) return 1'b0;
        dx = (px - ox) >> sc;
        dy = (py - oy) >> sc;
        if (dy >= 9) return 1'b0;
        d = dx / 5;
        c = dx % 5;
        if (d >= 2 || c >= 4) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0 && md[0] == 0) return 1'b0;
`endif
        s = font(md[d]);
        return s[dy*4 + c] == 8'h23;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One poll per cycle; Hit seen at this negedge answers the poll driven two negedges ago.
    task automatic poll_step(int px, int py, int ox, int oy, int sc, bit chk, bit exp, int tag);
        sb_t e;
        @(negedge clk);
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            if (e.chk) check($sformatf("hit#%0d", e.tag), int'(Hit), int'(e.exp));
        end
        PollX       = 10'(px);
        PollY       = 9'(py);
        ObjectX     = 10'(ox);
        ObjectY     = 9'(oy);
        ObjectScale = 2'(sc);
        sbq.push_back('{chk, exp, tag});
    endtask

    task automatic flush();
        poll_step(0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        poll_step(0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        sbq.delete();
    endtask

    task automatic mpoll(int px, int py, int ox, int oy, int sc, int tag);
        poll_step(px, py, ox, oy, sc, 1'b1, model_hit(px, py, ox, oy, sc), tag);
    endtask

    task automatic do_load(int v, bit spam, int spam_v, string nm);
        int n;
        @(negedge clk);
        Load  = 1'b1;
        Value = 7'(v);
        @(negedge clk);
        Load  = spam;
        Value = 7'(spam_v);
        n = 0;
        while (Busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        Load = 1'b0;
        check({nm, "_busy_cycles"}, n, 7);
        m_ov = (v > 99);
        if (v > 99) begin md[0] = 9; md[1] = 9; end
        else begin md[0] = v / 10; md[1] = v % 10; end
        check({nm, "_overflow"}, int'(Overflow), int'(m_ov));
    endtask

    task automatic rand_polls(int cnt, int tag0);
        int ox, oy, sc;
        for (int i = 0; i < cnt; i++) begin
            ox = 300;
            oy = 200;
            sc = int'($urandom_range(0, 2));
            mpoll(int'($urandom_range(298, 345)), int'($urandom_range(198, 240)), ox, oy, sc, tag0 + i);
        end
        flush();
    endtask

    initial begin
        // Digits "42", origin (200,100), scale 0, then scale 1 at origin (100,50).
        tbl[0]  = '{200, 100, 200, 100, 0, 1'b1};
        tbl[1]  = '{201, 100, 200, 100, 0, 1'b0};
        tbl[2]  = '{203, 105, 200, 100, 0, 1'b1};
        tbl[3]  = '{201, 104, 200, 100, 0, 1'b1};
        tbl[4]  = '{204, 100, 200, 100, 0, 1'b0};
        tbl[5]  = '{205, 104, 200, 100, 0, 1'b1};
        tbl[6]  = '{205, 101, 200, 100, 0, 1'b0};
        tbl[7]  = '{208, 101, 200, 100, 0, 1'b1};
        tbl[8]  = '{209, 100, 200, 100, 0, 1'b0};
        tbl[9]  = '{210, 100, 200, 100, 0, 1'b0};
        tbl[10] = '{200, 108, 200, 100, 0, 1'b0};
        tbl[11] = '{203, 108, 200, 100, 0, 1'b1};
        tbl[12] = '{200, 109, 200, 100, 0, 1'b0};
        tbl[13] = '{199, 100, 200, 100, 0, 1'b0};
        tbl[14] = '{200,  99, 200, 100, 0, 1'b0};
        tbl[15] = '{ 99,  50, 100,  50, 1, 1'b0};
        tbl[16] = '{100,  50, 100,  50, 1, 1'b1};
        tbl[17] = '{101,  50, 100,  50, 1, 1'b1};
        tbl[18] = '{110,  50, 100,  50, 1, 1'b1};
        tbl[19] = '{110,  58, 100,  50, 1, 1'b1};
        tbl[20] = '{102,  50, 100,  50, 1, 1'b0};

        rst_n = 1'b0; Load = 1'b0; Value = '0;
        ObjectX = '0; ObjectY = '0; ObjectScale = '0; PollX = '0; PollY = '0;
        md[0] = 0; md[1] = 0; m_ov = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(Busy), 0);
        check("reset_hit", int'(Hit), 0);
        check("reset_overflow", int'(Overflow), 0);
        rst_n = 1'b1;

        // Origin pixel of "00"
        mpoll(100, 50, 100, 50, 0, 1);
        mpoll(104, 50, 100, 50, 0, 2);
        mpoll(106, 54, 100, 50, 0, 3);
        flush();

        do_load(42, 1'b0, 0, "load42");
        for (int i = 0; i < 21; i++) begin
            poll_step(tbl[i].px, tbl[i].py, tbl[i].ox, tbl[i].oy, tbl[i].sc, 1'b1, tbl[i].exp, 100 + i);
        end
        flush();

        do_load(127, 1'b0, 0, "load127");
        mpoll(300, 200, 300, 200, 0, 200);
        mpoll(306, 201, 300, 200, 0, 201);
        mpoll(305, 205, 300, 200, 0, 202);
        flush();
        do_load(5, 1'b0, 0, "load5");
        rand_polls(16, 300);

        // Load held high through the conversion must be dropped
        do_load(42, 1'b1, 13, "load42_spam");
        rand_polls(16, 400);
        do_load(13, 1'b0, 0, "load13");
        rand_polls(20, 500);

        // Reset in the middle of a conversion
        @(negedge clk);
        Load = 1'b1; Value = 7'd100;
        @(negedge clk);
        Load = 1'b0;
        repeat (2) @(negedge clk);
        check("midshift_busy", int'(Busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy_immediate", int'(Busy), 0);
        check("rst_overflow", int'(Overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        md[0] = 0; md[1] = 0; m_ov = 1'b0;
        mpoll(300, 200, 300, 200, 0, 600);
        mpoll(301, 204, 300, 200, 0, 601);
        mpoll(305, 200, 300, 200, 0, 602);
        mpoll(306, 203, 300, 200, 0, 603);
        flush();
        @(negedge clk);
        check("post_rst_busy", int'(Busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
